// File: rtl/data_mem_pkg.sv
// Shared definitions for the parametrised data memory: access size codes,
// FSM encoding, LED register default address and small lane helpers.
package data_mem_pkg;

    localparam logic [2:0]  SZ_BYTE      = 3'b001;
    localparam logic [2:0]  SZ_HALF      = 3'b011;
    localparam logic [2:0]  SZ_WORD      = 3'b111;
    localparam int          SIGN_BIT     = 3;
    localparam logic [31:0] LED_ADDR_DEF = 32'h0000_2000;

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } state_e;

    function automatic logic size_legal(input logic [2:0] sz);
        return (sz == SZ_BYTE) || (sz == SZ_HALF) || (sz == SZ_WORD);
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data is copied into every lane so the byte
    // enables alone pick the destination.
    function automatic logic [31:0] replicate(input logic [2:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response bundle between the MEM-stage requester and the data memory.
interface data_mem_if #(
    parameter int NUM_LEDS = 8
);
    logic [31:0]         addr;
    logic [31:0]         write_data;
    logic                memwrite;
    logic                memread;
    logic [3:0]          sign_mask;
    logic [31:0]         read_data;
    logic [NUM_LEDS-1:0] led;
    logic                clk_stall;
    logic                misaligned;

    modport master (
        output addr, write_data, memwrite, memread, sign_mask,
        input  read_data, led, clk_stall, misaligned
    );

    modport slave (
        input  addr, write_data, memwrite, memread, sign_mask,
        output read_data, led, clk_stall, misaligned
    );
endinterface

// File: rtl/data_mem_param_load_extend.sv
// Load lane select plus sign/zero extension; purely combinational.
module load_extend
    import data_mem_pkg::*;
(
    input  logic [31:0] data_word,
    input  logic [1:0]  offset,
    input  logic [3:0]  sign_mask,
    output logic [31:0] result
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sgn;

    always_comb begin
        lane_b = data_word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? data_word[31:16] : data_word[15:0];
        sgn    = sign_mask[SIGN_BIT];
        case (sign_mask[2:0])
            SZ_BYTE: result = {{24{sgn & lane_b[7]}}, lane_b};
            SZ_HALF: result = {{16{sgn & lane_h[15]}}, lane_h};
            SZ_WORD: result = data_word;
            default: result = 32'h0;
        endcase
    end
endmodule

// File: rtl/data_mem_param.sv
// Word-organised data RAM with sized loads/stores, configurable load latency
// reported on clk_stall, misalignment flagging and a memory-mapped LED register.
module data_mem_param
    import data_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          READ_STALL  = 1,
    parameter logic [31:0] LED_ADDR    = LED_ADDR_DEF,
    parameter int          NUM_LEDS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    data_mem_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (READ_STALL > 0) ? $clog2(READ_STALL + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((READ_STALL > 0) ? READ_STALL - 1 : 0);

    logic [31:0] mem [DEPTH_WORDS];

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         hold_q, hold_d;
    logic [1:0]          off_q, off_d;
    logic [3:0]          mask_q, mask_d;
    logic [31:0]         read_data_q, read_data_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                stall_q, stall_d;
    logic                mis_q, mis_d;

    logic [2:0]       size;
    logic             bad;
    logic             accept;
    logic             is_led;
    logic [IDX_W-1:0] idx;
    logic [31:0]      src_word;
    logic [31:0]      now_ext;
    logic [31:0]      wait_ext;
    logic             do_store;
    logic             ram_we;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;

    always_comb begin
        size   = bus.sign_mask[2:0];
        bad    = !size_legal(size)
               || ((size == SZ_HALF) && bus.addr[0])
               || ((size == SZ_WORD) && (bus.addr[1:0] != 2'b00));
        accept = (state_q == IDLE) && !stall_q;
        // LED decode sees the full address; only the RAM index aliases.
        is_led   = (bus.addr == LED_ADDR);
        idx      = bus.addr[IDX_W+1:2];
        src_word = is_led ? 32'(led_q) : mem[idx];
        do_store = accept && bus.memwrite && !bus.memread && !bad;
        ram_we   = do_store && !is_led && !reset;
        be        = byte_en(size, bus.addr[1:0]);
        wdata_rep = replicate(size, bus.write_data);
    end

    load_extend u_ext_now (
        .data_word (src_word),
        .offset    (bus.addr[1:0]),
        .sign_mask (bus.sign_mask),
        .result    (now_ext)
    );

    load_extend u_ext_wait (
        .data_word (hold_q),
        .offset    (off_q),
        .sign_mask (mask_q),
        .result    (wait_ext)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        off_d       = off_q;
        mask_d      = mask_q;
        read_data_d = read_data_q;
        led_d       = led_q;
        stall_d     = stall_q;
        mis_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mis_d = (bus.memread || bus.memwrite)
                          && (bad || (bus.memread && bus.memwrite));
                    if (bus.memread) begin
                        if (bad) begin
                            read_data_d = 32'h0;
                        end else if (READ_STALL == 0) begin
                            read_data_d = now_ext;
                        end else begin
                            hold_d  = src_word;
                            off_d   = bus.addr[1:0];
                            mask_d  = bus.sign_mask;
                            cnt_d   = CNT_INIT;
                            stall_d = 1'b1;
                            state_d = READ_WAIT;
                        end
                    end
                    if (do_store && is_led) begin
                        if (size == SZ_BYTE) begin
                            for (int i = 0; i < NUM_LEDS; i++) begin
                                if (i < 8) led_d[i] = bus.write_data[i];
                            end
                        end else begin
                            led_d = bus.write_data[NUM_LEDS-1:0];
                        end
                    end
                end
            end
            READ_WAIT: begin
                if (cnt_q == '0) begin
                    read_data_d = wait_ext;
                    stall_d     = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= 32'h0;
            off_q       <= 2'b00;
            mask_q      <= 4'h0;
            read_data_q <= 32'h0;
            led_q       <= '0;
            stall_q     <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            off_q       <= off_d;
            mask_q      <= mask_d;
            read_data_q <= read_data_d;
            led_q       <= led_d;
            stall_q     <= stall_d;
            mis_q       <= mis_d;
        end
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.led        = led_q;
    assign bus.clk_stall  = stall_q;
    assign bus.misaligned = mis_q;

endmodule
